// File: rtl/postif_queue_pkg.sv
// rtl/postif_queue_pkg.sv - shared constants and entry layout for the post-IF queue and ID-side consumers
package postif_queue_pkg;

  localparam logic RST_ENABLE   = 1'b1;
  localparam int   DEF_PC_W     = 32;
  localparam int   DEF_EXC_W    = 32;
  localparam int   ENTRY_FLAG_W = 2;

  // Entry layout {pc, exc, ren, ivalid} at the default field widths.
  typedef struct packed {
    logic [DEF_PC_W-1:0]  pc;
    logic [DEF_EXC_W-1:0] exc;
    logic                 ren;
    logic                 ivalid;
  } postif_entry_t;

  function automatic logic [ENTRY_FLAG_W-1:0] make_flags(input logic ren,
                                                         input logic branch_shadow);
    return {ren, ~branch_shadow};
  endfunction

endpackage

// File: rtl/postif_queue_ptr.sv
// rtl/postif_queue_ptr.sv - head/tail pointers and occupancy counter with reset/flush priority
module postif_queue_ptr #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          flush_i,
  input  logic          wr_i,
  input  logic          rd_i,
  output logic [AW-1:0] head_o,
  output logic [AW-1:0] tail_o,
  output logic [CW-1:0] count_o
);

  // Pointers are exactly log2(DEPTH) wide, so natural overflow is the modulo wrap.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      head_o  <= '0;
      tail_o  <= '0;
      count_o <= '0;
    end else if (flush_i) begin
      head_o  <= '0;
      tail_o  <= '0;
      count_o <= '0;
    end else begin
      if (wr_i) tail_o <= tail_o + 1'b1;
      if (rd_i) head_o <= head_o + 1'b1;
      case ({wr_i, rd_i})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: rtl/postif_queue.sv
// rtl/postif_queue.sv - IF to post-IF decoupling FIFO; POSTIF_QUEUE_BYPASS_EN enables empty-queue bypass
module postif_queue
  import postif_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = DEF_PC_W,
  parameter int EXC_W = DEF_EXC_W,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             branch_enable_i,
  input  logic             if_valid_i,
  output logic             if_ready_o,
  input  logic [PC_W-1:0]  if_pc_i,
  input  logic [EXC_W-1:0] if_exception_type_i,
  input  logic             if_inst_ren_i,
  output logic             postif_valid_o,
  input  logic             postif_ready_i,
  output logic [PC_W-1:0]  postif_pc_o,
  output logic [EXC_W-1:0] postif_exception_type_o,
  output logic             postif_inst_ren_o,
  output logic             postif_inst_valid_o,
  output logic [CW-1:0]    count_o
);

  logic [PC_W-1:0]         pc_mem   [DEPTH];
  logic [EXC_W-1:0]        exc_mem  [DEPTH];
  logic [ENTRY_FLAG_W-1:0] flag_mem [DEPTH];

  logic [AW-1:0]           head;
  logic [AW-1:0]           tail;
  logic                    empty;
  logic                    full;
  logic                    enq;
  logic                    deq;
  logic                    bypass;
  logic                    wr;
  logic                    rd;
  logic [ENTRY_FLAG_W-1:0] in_flags;
  logic [ENTRY_FLAG_W-1:0] head_flags;

  assign empty    = (count_o == '0);
  assign full     = (count_o == CW'(DEPTH));
  assign in_flags = make_flags(if_inst_ren_i, branch_enable_i);

  assign if_ready_o = !full && !flush_i;
  assign enq        = if_valid_i && if_ready_o;

`ifdef POSTIF_QUEUE_BYPASS_EN
  assign bypass = empty && if_valid_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign postif_valid_o = !empty || bypass;
  assign deq            = postif_valid_o && postif_ready_i;

  // A bypassed entry taken downstream the same cycle never touches storage.
  assign wr = enq && !(bypass && postif_ready_i);
  assign rd = deq && !bypass;

  postif_queue_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .flush_i (flush_i),
    .wr_i    (wr),
    .rd_i    (rd),
    .head_o  (head),
    .tail_o  (tail),
    .count_o (count_o)
  );

  always_ff @(posedge clock_i) begin
    if (wr) begin
      pc_mem[tail]   <= if_pc_i;
      exc_mem[tail]  <= if_exception_type_i;
      flag_mem[tail] <= in_flags;
    end
  end

  assign head_flags = flag_mem[head];

  always_comb begin
    postif_pc_o             = '0;
    postif_exception_type_o = '0;
    postif_inst_ren_o       = 1'b0;
    postif_inst_valid_o     = 1'b0;
    if (bypass) begin
      postif_pc_o             = if_pc_i;
      postif_exception_type_o = if_exception_type_i;
      postif_inst_ren_o       = in_flags[1];
      postif_inst_valid_o     = in_flags[0];
    end else if (!empty) begin
      postif_pc_o             = pc_mem[head];
      postif_exception_type_o = exc_mem[head];
      postif_inst_ren_o       = head_flags[1];
      postif_inst_valid_o     = head_flags[0];
    end
  end

endmodule

// File: tb/tb_postif_queue.sv
// tb/tb_postif_queue.sv - self-checking bench for postif_queue against a queue-based model
module tb_postif_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        br;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] pc;
  logic [31:0] exc;
  logic        ren;
  logic        p_valid;
  logic        p_ready;
  logic [31:0] p_pc;
  logic [31:0] p_exc;
  logic        p_ren;
  logic        p_iv;
  logic [2:0]  count;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exc;
    logic        ren;
    logic        iv;
  } ent_t;

  ent_t mq[$];

  logic        e_ready, e_valid, e_byp, e_ren, e_iv;
  logic [31:0] e_pc, e_exc;
  logic [2:0]  e_count;

  always #5 clk = ~clk;

  postif_queue #(.DEPTH(DEPTH), .PC_W(32), .EXC_W(32)) dut (
    .clock_i                 (clk),
    .reset_i                 (rst),
    .flush_i                 (flush),
    .branch_enable_i         (br),
    .if_valid_i              (if_valid),
    .if_ready_o              (if_ready),
    .if_pc_i                 (pc),
    .if_exception_type_i     (exc),
    .if_inst_ren_i           (ren),
    .postif_valid_o          (p_valid),
    .postif_ready_i          (p_ready),
    .postif_pc_o             (p_pc),
    .postif_exception_type_o (p_exc),
    .postif_inst_ren_o       (p_ren),
    .postif_inst_valid_o     (p_iv),
    .count_o                 (count)
  );

  function automatic void model_eval();
    e_count = 3'(mq.size());
    e_ready = (mq.size() != DEPTH) && !flush;
`ifdef POSTIF_QUEUE_BYPASS_EN
    e_byp = (mq.size() == 0) && if_valid && !flush;
`else
    e_byp = 1'b0;
`endif
    e_valid = (mq.size() != 0) || e_byp;
    e_pc = '0; e_exc = '0; e_ren = 1'b0; e_iv = 1'b0;
    if (e_byp) begin
      e_pc = pc; e_exc = exc; e_ren = ren; e_iv = !br;
    end else if (mq.size() != 0) begin
      e_pc = mq[0].pc; e_exc = mq[0].exc; e_ren = mq[0].ren; e_iv = mq[0].iv;
    end
  endfunction

  task automatic tick();
    logic do_enq, do_deq, byp, fl, rdy;
    ent_t e;
    model_eval();
    do_enq = if_valid && e_ready;
    do_deq = e_valid && p_ready;
    byp    = e_byp;
    fl     = flush;
    rdy    = p_ready;
    e.pc = pc; e.exc = exc; e.ren = ren; e.iv = !br;
    @(posedge clk);
    if (fl) mq.delete();
    else if (!(byp && rdy)) begin
      if (do_deq) void'(mq.pop_front());
      if (do_enq) mq.push_back(e);
    end
    #1;
    model_eval();
  endtask

  task automatic idle_inputs();
    flush = 0; br = 0; if_valid = 0; pc = '0; exc = '0; ren = 0; p_ready = 0;
  endtask

  task automatic drain();
    idle_inputs();
    p_ready = 1;
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) tick();
    p_ready = 0;
    model_eval();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    mq.delete();
    #1;
    model_eval();
    n_total++;
    if ({if_ready, p_valid, count} !== {1'b1, 1'b0, 3'd0})
      $display("FAIL reset_ctl: got %b expected %b", {if_ready, p_valid, count}, {1'b1, 1'b0, 3'd0});
    else n_pass++;
    n_total++;
    if ({p_pc, p_exc, p_ren, p_iv} !== 66'd0)
      $display("FAIL reset_data: got %h expected 0", {p_pc, p_exc, p_ren, p_iv});
    else n_pass++;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    model_eval();
  endtask

  task automatic test_first_entry();
    idle_inputs();
    if_valid = 1; pc = 32'hBFC0_0000; ren = 1;
    tick();
    if_valid = 0;
    model_eval();
    n_total++;
    if ({p_valid, p_iv, p_ren, count} !== {1'b1, 1'b1, 1'b1, 3'd1})
      $display("FAIL first_ctl: got %b expected %b", {p_valid, p_iv, p_ren, count}, 6'b111001);
    else n_pass++;
    n_total++;
    if (p_pc !== 32'hBFC0_0000) $display("FAIL first_pc: got %h expected bfc00000", p_pc);
    else n_pass++;
  endtask

  task automatic test_full();
    drain();
    for (int i = 0; i < DEPTH; i++) begin
      if_valid = 1; pc = 32'(i * 4);
      tick();
    end
    pc = 32'h10;
    model_eval();
    n_total++;
    if ({if_ready, count} !== {1'b0, 3'd4})
      $display("FAIL full_ctl: got %b expected %b", {if_ready, count}, 4'b0100);
    else n_pass++;
    p_ready = 1;
    #1;
    n_total++;
    if ({if_ready, p_pc} !== {1'b0, 32'h0})
      $display("FAIL full_deq: got %h expected %h", {if_ready, p_pc}, 33'h0);
    else n_pass++;
    tick();
    p_ready = 0; if_valid = 0;
    #1;
    model_eval();
    n_total++;
    if ({if_ready, count, p_pc} !== {1'b1, 3'd3, 32'h4})
      $display("FAIL full_after: got %h expected %h", {if_ready, count, p_pc}, {1'b1, 3'd3, 32'h4});
    else n_pass++;
  endtask

  task automatic test_stream();
    drain();
    if_valid = 1; pc = 32'h100;
    tick();
    for (int k = 0; k < 10; k++) begin
      if_valid = 1; pc = 32'h104 + 32'(4 * k); p_ready = 1;
      #1;
      n_total++;
      if ({p_pc, count} !== {32'h100 + 32'(4 * k), 3'd1})
        $display("FAIL stream_%0d: got %h expected %h", k, {p_pc, count}, {32'h100 + 32'(4 * k), 3'd1});
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_branch_kill();
    drain();
    if_valid = 1; pc = 32'h20; br = 1;
    tick();
    if_valid = 0; br = 0;
    #1;
    n_total++;
    if ({p_valid, p_pc, p_iv} !== {1'b1, 32'h20, 1'b0})
      $display("FAIL branch_kill: got %h expected %h", {p_valid, p_pc, p_iv}, {1'b1, 32'h20, 1'b0});
    else n_pass++;
  endtask

  task automatic test_flush();
    drain();
    for (int i = 0; i < 3; i++) begin
      if_valid = 1; pc = 32'h30 + 32'(4 * i);
      tick();
    end
    flush = 1; pc = 32'h3C; p_ready = 1;
    #1;
    n_total++;
    if (if_ready !== 1'b0) $display("FAIL flush_ready: got %b expected 0", if_ready);
    else n_pass++;
    tick();
    flush = 0; if_valid = 0; p_ready = 0;
    #1;
    n_total++;
    if ({p_valid, count} !== {1'b0, 3'd0})
      $display("FAIL flush_state: got %b expected 0000", {p_valid, count});
    else n_pass++;
    if_valid = 1; pc = 32'h50;
    tick();
    if_valid = 0;
    #1;
    n_total++;
    if ({p_pc, count} !== {32'h50, 3'd1})
      $display("FAIL flush_next: got %h expected %h", {p_pc, count}, {32'h50, 3'd1});
    else n_pass++;
  endtask

  task automatic test_bypass();
    drain();
    if_valid = 1; pc = 32'h40; p_ready = 1;
    #1;
`ifdef POSTIF_QUEUE_BYPASS_EN
    n_total++;
    if ({p_valid, p_pc, p_iv, count} !== {1'b1, 32'h40, 1'b1, 3'd0})
      $display("FAIL bypass_same: got %h expected %h", {p_valid, p_pc, p_iv, count}, {1'b1, 32'h40, 1'b1, 3'd0});
    else n_pass++;
    tick();
    if_valid = 0; p_ready = 0;
    #1;
    n_total++;
    if ({p_valid, count} !== {1'b0, 3'd0})
      $display("FAIL bypass_after: got %b expected 0000", {p_valid, count});
    else n_pass++;
`else
    n_total++;
    if ({p_valid, p_pc} !== {1'b0, 32'h0})
      $display("FAIL nobypass_same: got %h expected 0", {p_valid, p_pc});
    else n_pass++;
    tick();
    if_valid = 0; p_ready = 0;
    #1;
    n_total++;
    if ({p_valid, p_pc, count} !== {1'b1, 32'h40, 3'd1})
      $display("FAIL nobypass_after: got %h expected %h", {p_valid, p_pc, count}, {1'b1, 32'h40, 3'd1});
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    drain();
    for (int c = 0; c < 400; c++) begin
      flush    = ($urandom_range(15) == 0);
      br       = ($urandom_range(3) == 0);
      if_valid = ($urandom_range(3) != 0);
      p_ready  = $urandom_range(1);
      pc       = $urandom;
      exc      = $urandom;
      ren      = $urandom_range(1);
      #1;
      model_eval();
      n_total++;
      if ({if_ready, p_valid, count} !== {e_ready, e_valid, e_count})
        $display("FAIL rand_ctl_%0d: got %b expected %b", c, {if_ready, p_valid, count}, {e_ready, e_valid, e_count});
      else n_pass++;
      n_total++;
      if ({p_pc, p_exc, p_ren, p_iv} !== {e_pc, e_exc, e_ren, e_iv})
        $display("FAIL rand_data_%0d: got %h expected %h", c, {p_pc, p_exc, p_ren, p_iv}, {e_pc, e_exc, e_ren, e_iv});
      else n_pass++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    drain();
    for (int i = 0; i < 3; i++) begin
      if_valid = 1; pc = 32'h70 + 32'(4 * i);
      tick();
    end
    if_valid = 0;
    #1;
    rst = 1;
    mq.delete();
    #1;
    model_eval();
    n_total++;
    if ({if_ready, p_valid, count, p_pc} !== {e_ready, e_valid, e_count, e_pc})
      $display("FAIL async_reset: got %h expected %h", {if_ready, p_valid, count, p_pc}, {e_ready, e_valid, e_count, e_pc});
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_first_entry();
    test_full();
    test_stream();
    test_branch_kill();
    test_flush();
    test_bypass();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
